// File: rtl/alu_req_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_unit
// Purpose  : Request/response execution unit for the 4-op baby ALU
//            (AND, ADD, SUB, SRAI). It accepts one operation per
//            valid/ready handshake and returns a registered result on a
//            valid/ready response channel. AND/ADD/SUB and SRAI by zero
//            complete in one cycle. SRAI by k>0 shifts one bit per cycle
//            and takes k cycles.
// Ports    : clk        - system clock, rising edge
//            rst_n      - asynchronous active-low reset
//            req_valid  - request present
//            req_ready  - unit can accept a request this cycle
//            req_in0    - operand A
//            req_in1    - operand B (SRAI uses bits [SHW-1:0] as amount)
//            req_op     - 00 AND, 01 ADD, 10 SUB, 11 SRAI
//            rsp_valid  - result present
//            rsp_ready  - consumer takes the result this cycle
//            rsp_data   - result
//            rsp_op     - opcode that produced rsp_data
//            rsp_zero   - result == 0          (only with ALU_FLAGS_EN)
//            rsp_carry  - carry / no-borrow /
//                         last bit shifted out (only with ALU_FLAGS_EN)
// Options  : define ALU_FLAGS_EN to add the rsp_zero/rsp_carry flag outputs.
// Revision : 1.0 - initial release
// ============================================================================
module alu_req_unit #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_in0,
    input  logic [WIDTH-1:0] req_in1,
    input  logic [1:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
`ifdef ALU_FLAGS_EN
    output logic             rsp_zero,
    output logic             rsp_carry,
`endif
    output logic [1:0]       rsp_op
);

    localparam logic [1:0] c_OP_AND  = 2'b00;
    localparam logic [1:0] c_OP_ADD  = 2'b01;
    localparam logic [1:0] c_OP_SUB  = 2'b10;
    localparam logic [1:0] c_OP_SRAI = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]         rsp_op_q, rsp_op_d;

    logic               w_out_free;
    logic               w_req_ready;
    logic               w_accept;
    logic [SHW-1:0]     w_amt;
    logic               w_multi;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_work_shr;

`ifdef ALU_FLAGS_EN
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic [WIDTH:0]     w_sum_ext;
    logic               w_carry;
`endif

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_out_free  = !rsp_valid_q || rsp_ready;
    // Gated with rst_n so the unit never advertises readiness in reset.
    assign w_req_ready = rst_n && (state_q == S_IDLE) && w_out_free;
    assign w_accept    = req_valid && w_req_ready;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign w_amt      = req_in1[SHW-1:0];
    assign w_multi    = (req_op == c_OP_SRAI) && (w_amt != '0);
    assign w_work_shr = {work_q[WIDTH-1], work_q[WIDTH-1:1]};

    // Single-cycle result. SRAI only reaches this path with amount 0,
    // where the result is operand A unchanged.
    always_comb begin
        w_res = req_in0;
        case (req_op)
            c_OP_AND: w_res = req_in0 & req_in1;
            c_OP_ADD: w_res = req_in0 + req_in1;
            c_OP_SUB: w_res = req_in0 - req_in1;
            default:  w_res = req_in0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    assign w_sum_ext = {1'b0, req_in0} + {1'b0, req_in1};

    always_comb begin
        w_carry = 1'b0;
        case (req_op)
            c_OP_ADD: w_carry = w_sum_ext[WIDTH];
            c_OP_SUB: w_carry = (req_in0 >= req_in1);
            default:  w_carry = 1'b0;
        endcase
    end
`endif

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_op_d    = rsp_op_q;
`ifdef ALU_FLAGS_EN
        rsp_zero_d  = rsp_zero_q;
        rsp_carry_d = rsp_carry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
                if (w_accept) begin
                    if (w_multi) begin
                        work_d  = req_in0;
                        cnt_d   = w_amt;
                        state_d = S_SHIFT;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = w_res;
                        rsp_op_d    = req_op;
`ifdef ALU_FLAGS_EN
                        rsp_zero_d  = (w_res == '0);
                        rsp_carry_d = w_carry;
`endif
                    end
                end
            end
            S_SHIFT: begin
                // Output register is empty here: SHIFT is only entered
                // when the output was free, so no stall is needed.
                work_d = w_work_shr;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = w_work_shr;
                    rsp_op_d    = c_OP_SRAI;
                    state_d     = S_IDLE;
`ifdef ALU_FLAGS_EN
                    rsp_zero_d  = (w_work_shr == '0);
                    rsp_carry_d = work_q[0];
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_op_q    <= 2'b00;
`ifdef ALU_FLAGS_EN
            rsp_zero_q  <= 1'b0;
            rsp_carry_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_op_q    <= rsp_op_d;
`ifdef ALU_FLAGS_EN
            rsp_zero_q  <= rsp_zero_d;
            rsp_carry_q <= rsp_carry_d;
`endif
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_op    = rsp_op_q;
`ifdef ALU_FLAGS_EN
    assign rsp_zero  = rsp_zero_q;
    assign rsp_carry = rsp_carry_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_req_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_req_unit
// Purpose  : Self-checking bench for alu_req_unit. A transaction-level
//            reference model tracks what the response channel and req_ready
//            must show after every clock edge; directed vectors add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_req_unit;

    localparam int WIDTH = 8;
    localparam int SHW   = $clog2(WIDTH);

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_in0;
    logic [WIDTH-1:0] req_in1;
    logic [1:0]       req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [1:0]       rsp_op;
`ifdef ALU_FLAGS_EN
    logic             rsp_zero;
    logic             rsp_carry;
`endif

    alu_req_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in0   (req_in0),
        .req_in1   (req_in1),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
`ifdef ALU_FLAGS_EN
        .rsp_zero  (rsp_zero),
        .rsp_carry (rsp_carry),
`endif
        .rsp_op    (rsp_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: outcome of each operation plus how many cycles
    // the unit stays busy. Updated once per rising edge from the inputs
    // that were stable at that edge.
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] ref_res(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        int k;
        k = int'(b[SHW-1:0]);
        case (op)
            2'b00:   return a & b;
            2'b01:   return WIDTH'(int'(a) + int'(b));
            2'b10:   return WIDTH'(int'(a) - int'(b));
            default: return WIDTH'($signed(a) >>> k);
        endcase
    endfunction

    function automatic logic ref_carry(input logic [1:0] op,
                                       input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
        int k;
        k = int'(b[SHW-1:0]);
        case (op)
            2'b00:   return 1'b0;
            2'b01:   return (int'(a) + int'(b)) >= (1 << WIDTH);
            2'b10:   return int'(a) >= int'(b);
            default: return (k == 0) ? 1'b0 : a[k-1];
        endcase
    endfunction

    logic             m_valid = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    logic [1:0]       m_op    = 2'b00;
    logic             m_zero  = 1'b0;
    logic             m_carry = 1'b0;
    int               m_busy  = 0;
    logic [WIDTH-1:0] m_pend;
    logic             m_pend_c;

    initial begin
        logic             s_rst, s_v, s_rr, free, exp_ready;
        logic [1:0]       s_op;
        logic [WIDTH-1:0] s_a, s_b;
        int               k;
        forever begin
            @(posedge clk);
            s_rst = rst_n; s_v = req_valid; s_rr = rsp_ready;
            s_op = req_op; s_a = req_in0; s_b = req_in1;
            if (!s_rst) begin
                m_valid = 1'b0; m_data = '0; m_op = 2'b00;
                m_zero = 1'b0; m_carry = 1'b0; m_busy = 0;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_valid = 1'b1; m_data = m_pend; m_op = 2'b11;
                    m_zero = (m_pend == '0); m_carry = m_pend_c;
                end
            end else begin
                free = !m_valid || s_rr;
                if (s_rr) m_valid = 1'b0;
                if (free && s_v) begin
                    k = int'(s_b[SHW-1:0]);
                    if (s_op == 2'b11 && k > 0) begin
                        m_busy   = k;
                        m_pend   = ref_res(s_op, s_a, s_b);
                        m_pend_c = ref_carry(s_op, s_a, s_b);
                    end else begin
                        m_valid = 1'b1;
                        m_data  = ref_res(s_op, s_a, s_b);
                        m_op    = s_op;
                        m_zero  = (m_data == '0);
                        m_carry = ref_carry(s_op, s_a, s_b);
                    end
                end
            end
            #1;
            exp_ready = rst_n && (m_busy == 0) && (!m_valid || rsp_ready);
            chk("model_req_ready", 32'(req_ready), 32'(exp_ready));
            chk("model_rsp_valid", 32'(rsp_valid), 32'(m_valid));
            if (m_valid) begin
                chk("model_rsp_data", 32'(rsp_data), 32'(m_data));
                chk("model_rsp_op", 32'(rsp_op), 32'(m_op));
`ifdef ALU_FLAGS_EN
                chk("model_rsp_zero", 32'(rsp_zero), 32'(m_zero));
                chk("model_rsp_carry", 32'(rsp_carry), 32'(m_carry));
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Present a request at the next falling edge and hold it until it is
    // accepted. Returns 1 ns after the accepting edge.
    task automatic do_req(input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, output int acc_cyc);
        logic got;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_in0 = a; req_in1 = b;
        got = 1'b0;
        for (int t = 0; t < 50; t++) begin
            #4;
            got = req_ready;
            @(posedge clk);
            if (got) break;
            @(negedge clk);
        end
        if (!got) chk("accept_timeout", 32'(got), 32'd1);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 2'b00; req_in0 = '0; req_in1 = '0;
    endtask

    // Wait until rsp_valid is high, counting samples with req_ready low.
    task automatic wait_rsp(output logic [WIDTH-1:0] d, output logic [1:0] o,
                            output int rcyc, output int lows);
        logic got;
        got = 1'b0; lows = 0;
        for (int t = 0; t < 40; t++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (!req_ready) lows++;
            @(posedge clk);
            #1;
        end
        if (!got) chk("response_timeout", 32'(got), 32'd1);
        d = rsp_data; o = rsp_op; rcyc = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed vectors
    // ------------------------------------------------------------------
    initial begin
        int               a_c, r_c, r_c1, lows;
        logic [WIDTH-1:0] d;
        logic [1:0]       o;
        logic             seen;

        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        req_op = 2'b00; req_in0 = '0; req_in1 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'h00);
        chk("reset_req_ready", 32'(req_ready), 32'd1);

        // Back-to-back AND then ADD
        do_req(2'b00, 8'h02, 8'h02, a_c);
        wait_rsp(d, o, r_c1, lows);
        chk("and_data", 32'(d), 32'h02);
        chk("and_op", 32'(o), 32'h0);
        do_req(2'b01, 8'hF0, 8'hAA, a_c);
        wait_rsp(d, o, r_c, lows);
        chk("add_data", 32'(d), 32'h9A);
        chk("add_op", 32'(o), 32'h1);
        chk("b2b_spacing", 32'(r_c - r_c1), 32'd1);
`ifdef ALU_FLAGS_EN
        chk("add_carry", 32'(rsp_carry), 32'd1);
        chk("add_zero", 32'(rsp_zero), 32'd0);
`endif

        // SUB
        do_req(2'b10, 8'hF0, 8'hAA, a_c);
        wait_rsp(d, o, r_c, lows);
        chk("sub_data", 32'(d), 32'h46);
        chk("sub_op", 32'(o), 32'h2);
`ifdef ALU_FLAGS_EN
        chk("sub_carry", 32'(rsp_carry), 32'd1);
`endif
        idle();

        // SRAI 1F by 4
        do_req(2'b11, 8'h1F, 8'h04, a_c);
        idle();
        wait_rsp(d, o, r_c, lows);
        chk("srai4_data", 32'(d), 32'h01);
        chk("srai4_op", 32'(o), 32'h3);
        chk("srai4_latency", 32'(r_c - a_c), 32'd4);
        chk("srai4_ready_low", 32'(lows), 32'd4);
`ifdef ALU_FLAGS_EN
        chk("srai4_carry", 32'(rsp_carry), 32'd1);
`endif

        // SRAI 80 by 3 (sign replicated)
        do_req(2'b11, 8'h80, 8'h03, a_c);
        idle();
        wait_rsp(d, o, r_c, lows);
        chk("srai3_data", 32'(d), 32'hF0);
        chk("srai3_latency", 32'(r_c - a_c), 32'd3);

        // SRAI by 0 (single cycle), then amount with upper bits set
        do_req(2'b11, 8'h80, 8'h00, a_c);
        wait_rsp(d, o, r_c, lows);
        chk("srai0_data", 32'(d), 32'h80);
        chk("srai0_latency", 32'(r_c - a_c), 32'd0);
`ifdef ALU_FLAGS_EN
        chk("srai0_carry", 32'(rsp_carry), 32'd0);
`endif
        do_req(2'b11, 8'h40, 8'hFA, a_c);
        idle();
        wait_rsp(d, o, r_c, lows);
        chk("srai_upper_ignored", 32'(d), 32'h10);
        chk("srai2_latency", 32'(r_c - a_c), 32'd2);

        // Backpressure
        idle();
        @(negedge clk);
        rsp_ready = 1'b0;
        do_req(2'b01, 8'h01, 8'h01, a_c);
        chk("bp_first_data", 32'(rsp_data), 32'h02);
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b00; req_in0 = 8'h0F; req_in1 = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_data", 32'(rsp_data), 32'h02);
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #4;
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp_next_data", 32'(rsp_data), 32'h0C);
        chk("bp_next_op", 32'(rsp_op), 32'h0);
        chk("bp_next_valid", 32'(rsp_valid), 32'd1);
        idle();

        // Reset in the middle of SRAI 7F by 7
        do_req(2'b11, 8'h7F, 8'h07, a_c);
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_rel_ready", 32'(req_ready), 32'd1);
        chk("rst_rel_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rel_data", 32'(rsp_data), 32'h00);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        chk("rst_no_response", 32'(seen), 32'd0);
        do_req(2'b01, 8'h10, 8'h20, a_c);
        wait_rsp(d, o, r_c, lows);
        chk("post_rst_add", 32'(d), 32'h30);
        idle();
        repeat (3) @(posedge clk);
        #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
